// File: rtl/smux_sel_arb_if.sv
// Handshake bundle between the two mux sources and the select arbiter.
// The lock signal exists only when SMUX_ARB_LOCK_EN is defined.
interface smux_sel_arb_if;
   logic req_a;
   logic req_b;
`ifdef SMUX_ARB_LOCK_EN
   logic lock;
`endif
   logic sel;
   logic gnt_a;
   logic gnt_b;
   logic sw;

`ifdef SMUX_ARB_LOCK_EN
   modport master (output req_a, output req_b, output lock,
                   input sel, input gnt_a, input gnt_b, input sw);
   modport slave  (input req_a, input req_b, input lock,
                   output sel, output gnt_a, output gnt_b, output sw);
`else
   modport master (output req_a, output req_b,
                   input sel, input gnt_a, input gnt_b, input sw);
   modport slave  (input req_a, input req_b,
                   output sel, output gnt_a, output gnt_b, output sw);
`endif
endinterface

// File: rtl/smux_sel_arb.sv
// Round-robin select arbiter with minimum dwell in front of the 2:1 select mux.
// Optional grant freeze input enabled by defining SMUX_ARB_LOCK_EN.
module smux_sel_arb #(
   parameter int MIN_DWELL = 4,
   parameter int CNT_W     = 4
) (
   input logic           clk,
   input logic           rst,
   smux_sel_arb_if.slave bus
);

   typedef enum logic [1:0] {IDLE, HOLD_A, HOLD_B} state_t;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(MIN_DWELL - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;
   logic             sel_q, sel_d;
   logic             sw_q, sw_d;
   logic             locked;
   logic             dwellDone;

`ifdef SMUX_ARB_LOCK_EN
   assign locked = bus.lock;
`else
   assign locked = 1'b0;
`endif

   assign dwellDone = (cnt_q == DWELL_LAST);

   // last_q is 1 when A was served most recently; a tie goes to the other source.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      sel_d   = sel_q;
      sw_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_a && bus.req_b) begin
               state_d = last_q ? HOLD_B : HOLD_A;
            end else if (bus.req_a) begin
               state_d = HOLD_A;
            end else if (bus.req_b) begin
               state_d = HOLD_B;
            end
         end
         HOLD_A: begin
            if (!dwellDone) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (!locked) begin
               if (bus.req_b) begin
                  state_d = HOLD_B;
               end else if (!bus.req_a) begin
                  state_d = IDLE;
               end
            end
         end
         HOLD_B: begin
            if (!dwellDone) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (!locked) begin
               if (bus.req_a) begin
                  state_d = HOLD_A;
               end else if (!bus.req_b) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Entering a hold restarts the dwell and steers the mux to the new owner.
      if (state_d != state_q && state_d != IDLE) begin
         cnt_d  = '0;
         sel_d  = (state_d == HOLD_A);
         last_d = (state_d == HOLD_A);
      end
      sw_d = (sel_d != sel_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         sel_q   <= 1'b0;
         sw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         sw_q    <= sw_d;
      end
   end

   assign bus.sel   = sel_q;
   assign bus.gnt_a = (state_q == HOLD_A);
   assign bus.gnt_b = (state_q == HOLD_B);
   assign bus.sw    = sw_q;

endmodule

// File: tb/tb_smux_sel_arb.sv
// Bench for smux_sel_arb: two instances (MIN_DWELL 4 and 1) share stimulus and are
// compared against an owner/age reference model; lock scenario needs SMUX_ARB_LOCK_EN.
module tb_smux_sel_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic reqA;
   logic reqB;
   logic lockIn;

   int checks = 0;
   int errors = 0;

   smux_sel_arb_if bus4 ();
   smux_sel_arb_if bus1 ();

   assign bus4.req_a = reqA;
   assign bus4.req_b = reqB;
   assign bus1.req_a = reqA;
   assign bus1.req_b = reqB;
`ifdef SMUX_ARB_LOCK_EN
   assign bus4.lock = lockIn;
   assign bus1.lock = lockIn;
`endif

   smux_sel_arb #(.MIN_DWELL(4), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   smux_sel_arb #(.MIN_DWELL(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Model: owner 0=none 1=A 2=B, age = cycles the current owner has held the grant.
   int dwell [2] = '{4, 1};
   int mOwner [2];
   int mAge [2];
   bit mLastA [2];
   bit mSel [2];
   bit mSw [2];

   task automatic modelStep();
      for (int i = 0; i < 2; i++) begin
         int nxt;
         bit otherReq;
         bit ownReq;
         if (rst) begin
            mOwner[i] = 0;
            mAge[i]   = 0;
            mLastA[i] = 1'b0;
            mSel[i]   = 1'b0;
            mSw[i]    = 1'b0;
         end else begin
            nxt = mOwner[i];
            if (mOwner[i] == 0) begin
               if (reqA && reqB) nxt = mLastA[i] ? 2 : 1;
               else if (reqA) nxt = 1;
               else if (reqB) nxt = 2;
            end else if (mAge[i] >= dwell[i] && !lockIn) begin
               otherReq = (mOwner[i] == 1) ? reqB : reqA;
               ownReq   = (mOwner[i] == 1) ? reqA : reqB;
               if (otherReq) nxt = 3 - mOwner[i];
               else if (!ownReq) nxt = 0;
            end
            mSw[i] = 1'b0;
            if (nxt != 0 && nxt != mOwner[i]) begin
               mAge[i]   = 1;
               mSw[i]    = (mSel[i] != (nxt == 1));
               mSel[i]   = (nxt == 1);
               mLastA[i] = (nxt == 1);
            end else if (nxt != 0) begin
               mAge[i]++;
            end else begin
               mAge[i] = 0;
            end
            mOwner[i] = nxt;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   // Packs {sel, gnt_a, gnt_b, sw}.
   function automatic logic [3:0] obs(int i);
      if (i == 0) return {bus4.sel, bus4.gnt_a, bus4.gnt_b, bus4.sw};
      return {bus1.sel, bus1.gnt_a, bus1.gnt_b, bus1.sw};
   endfunction

   function automatic logic [3:0] expv(int i);
      return {mSel[i], mOwner[i] == 1, mOwner[i] == 2, mSw[i]};
   endfunction

   task automatic test_reset();
      rst = 1'b1; reqA = 1'b1; reqB = 1'b1; lockIn = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 4'b0000) begin
               $display("[TB] FAIL reset_hold dut%0d: got %b expected 0000", i, obs(i));
               errors++;
            end
         end
      end
      rst = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs(i) !== 4'b1101) begin
            $display("[TB] FAIL reset_first_grant dut%0d: got %b expected 1101", i, obs(i));
            errors++;
         end
      end
   endtask

   task automatic test_single_request();
      int gntCnt;
      int swCnt;
      reqA = 1'b0; reqB = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      reqB = 1'b1;
      tick();
      reqB = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               $display("[TB] FAIL single_b dut%0d: got %b expected %b", i, obs(i), expv(i));
               errors++;
            end
         end
      end
      gntCnt = 0;
      swCnt  = 0;
      reqA = 1'b1;
      for (int c = 0; c < 9; c++) begin
         tick();
         reqA = 1'b0;
         if (bus4.gnt_a === 1'b1) gntCnt++;
         if (bus4.sw === 1'b1) swCnt++;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               $display("[TB] FAIL single_a dut%0d: got %b expected %b", i, obs(i), expv(i));
               errors++;
            end
         end
      end
      checks++;
      if (gntCnt != 4) begin
         $display("[TB] FAIL single_a_len: got %0d cycles expected 4", gntCnt);
         errors++;
      end
      checks++;
      if (swCnt != 1) begin
         $display("[TB] FAIL single_a_sw: got %0d pulses expected 1", swCnt);
         errors++;
      end
      checks++;
      if (obs(0) !== 4'b1000) begin
         $display("[TB] FAIL single_a_idle: got %b expected 1000", obs(0));
         errors++;
      end
   endtask

   task automatic test_contention();
      int sw4;
      int sw1;
      sw4 = 0;
      sw1 = 0;
      reqA = 1'b1; reqB = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus4.sw === 1'b1) sw4++;
         if (bus1.sw === 1'b1) sw1++;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               $display("[TB] FAIL contention dut%0d cyc%0d: got %b expected %b", i, c, obs(i), expv(i));
               errors++;
            end
            checks++;
            if (obs(i) ==? 4'b?11?) begin
               $display("[TB] FAIL both_grants dut%0d: got %b expected one-hot grants", i, obs(i));
               errors++;
            end
         end
      end
      checks++;
      if (sw4 != 5) begin
         $display("[TB] FAIL contention_sw_dwell4: got %0d pulses expected 5", sw4);
         errors++;
      end
      checks++;
      if (sw1 != 20) begin
         $display("[TB] FAIL contention_sw_dwell1: got %0d pulses expected 20", sw1);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      found = 1'b0;
      reqA = 1'b1; reqB = 1'b1;
      for (int c = 0; c < 12 && !found; c++) begin
         tick();
         if (mOwner[0] == 2 && mAge[0] == 2) found = 1'b1;
      end
      checks++;
      if (!found) begin
         $display("[TB] FAIL reset_mid_reach: got no HOLD_B cycle 2 expected within 12 cycles");
         errors++;
      end
      checks++;
      if (obs(0) !== 4'b0010) begin
         $display("[TB] FAIL reset_mid_holdb: got %b expected 0010", obs(0));
         errors++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs(i) !== 4'b0000) begin
            $display("[TB] FAIL reset_mid dut%0d: got %b expected 0000", i, obs(i));
            errors++;
         end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs(i) !== 4'b1101) begin
            $display("[TB] FAIL reset_mid_release dut%0d: got %b expected 1101", i, obs(i));
            errors++;
         end
      end
   endtask

`ifdef SMUX_ARB_LOCK_EN
   task automatic test_lock();
      rst = 1'b1; reqA = 1'b0; reqB = 1'b0; lockIn = 1'b0;
      tick();
      rst = 1'b0; reqA = 1'b1;
      tick();
      lockIn = 1'b1; reqB = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== {1'b1, 1'b1, 1'b0, (c == 0) ? 1'b0 : 1'b0}) begin
               $display("[TB] FAIL lock_hold dut%0d cyc%0d: got %b expected 1100", i, c, obs(i));
               errors++;
            end
         end
      end
      lockIn = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs(i) !== 4'b0011) begin
            $display("[TB] FAIL lock_release dut%0d: got %b expected 0011", i, obs(i));
            errors++;
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         reqA = 1'($urandom_range(0, 1));
         reqB = 1'($urandom_range(0, 1));
         rst  = ($urandom_range(0, 49) == 0);
`ifdef SMUX_ARB_LOCK_EN
         lockIn = ($urandom_range(0, 3) == 0);
`endif
         tick();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               $display("[TB] FAIL random dut%0d cyc%0d: got %b expected %b", i, c, obs(i), expv(i));
               errors++;
            end
         end
      end
      rst = 1'b0; reqA = 1'b0; reqB = 1'b0; lockIn = 1'b0;
   endtask

   initial begin
      rst = 1'b1; reqA = 1'b0; reqB = 1'b0; lockIn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mOwner[i] = 0; mAge[i] = 0; mLastA[i] = 1'b0; mSel[i] = 1'b0; mSw[i] = 1'b0;
      end
      test_reset();
      test_single_request();
      test_contention();
      test_reset_mid();
`ifdef SMUX_ARB_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
